// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared digit width, FSM encoding and BCD digit helpers
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PASS1  = 3'd1;
    localparam logic [2:0] ST_RECOMP = 3'd2;
    localparam logic [2:0] ST_DEC    = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PASS1  = ST_PASS1,
        RECOMP = ST_RECOMP,
        DEC    = ST_DEC,
        FIN    = ST_FIN
    } state_t;

    // Nine's complement of a valid BCD digit.
    function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] d);
        return 4'd9 - d;
    endfunction

    // True when the nibble is a legal BCD digit (0..9).
    function automatic logic bcd_is_valid(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - one-digit BCD adder with +6 decimal correction
module bcd_digit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] raw;
    logic [4:0] corrected;

    // Binary sum is at most 9+9+1 = 19, so a single +6 brings it back into BCD.
    assign raw       = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    assign cout      = raw > 5'd9;
    assign corrected = raw + 5'd6;
    assign s         = cout ? corrected[3:0] : raw[3:0];

endmodule

// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial BCD add/subtract with recomplement and GRS ulp correction
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 7,
    parameter int GRS_W   = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op,
    input  logic [DIGIT_W*NDIGITS-1:0]   a,
    input  logic [DIGIT_W*NDIGITS-1:0]   b,
    input  logic [GRS_W-1:0]             grs,
    output logic                         busy,
    output logic                         done,
    output logic [DIGIT_W*NDIGITS-1:0]   result,
    output logic                         sign,
    output logic                         carry_out,
    output logic                         invalid
);

    localparam int W     = DIGIT_W * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 op_q;
    logic [GRS_W-1:0]     grs_q;
    logic                 carry;
    logic                 nz;

    logic [DIGIT_W-1:0]   add_x;
    logic [DIGIT_W-1:0]   add_y;
    logic [DIGIT_W-1:0]   sum_d;
    logic                 cout_d;
    logic                 inputs_bad;
    logic                 last_digit;
    logic                 mag_zero;

    // Operand mux for the single shared digit adder: PASS1 works on a/b,
    // RECOMP and DEC rework the result register in place.
    always_comb begin
        add_x = a_q[DIGIT_W-1:0];
        add_y = op_q ? nines_comp(b_q[DIGIT_W-1:0]) : b_q[DIGIT_W-1:0];
        case (state)
            RECOMP: begin
                add_x = nines_comp(result[DIGIT_W-1:0]);
                add_y = '0;
            end
            DEC: begin
                add_x = result[DIGIT_W-1:0];
                add_y = 4'd9;
            end
            default: ;
        endcase
    end

    bcd_digit_adder u_digit_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (carry),
        .s    (sum_d),
        .cout (cout_d)
    );

    // Flag any non-BCD nibble in either incoming operand.
    always_comb begin
        inputs_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!bcd_is_valid(a[i*DIGIT_W +: DIGIT_W]) || !bcd_is_valid(b[i*DIGIT_W +: DIGIT_W]))
                inputs_bad = 1'b1;
        end
    end

    assign last_digit = (cnt == CNT_W'(NDIGITS - 1));
    // Magnitude is zero when no earlier digit was nonzero and the MSD being written is zero.
    assign mag_zero   = !nz && (sum_d == '0);

    // Sequencer: digit counter, shift registers, carry flop and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            grs_q     <= '0;
            carry     <= 1'b0;
            nz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            sign      <= 1'b0;
            carry_out <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op;
                        grs_q     <= grs;
                        busy      <= 1'b1;
                        sign      <= 1'b0;
                        carry_out <= 1'b0;
                        cnt       <= '0;
                        nz        <= 1'b0;
                        if (inputs_bad) begin
                            invalid <= 1'b1;
                            result  <= '0;
                            state   <= FIN;
                        end else begin
                            invalid <= 1'b0;
                            carry   <= op;
                            state   <= PASS1;
                        end
                    end
                end
                PASS1: begin
                    a_q    <= a_q >> DIGIT_W;
                    b_q    <= b_q >> DIGIT_W;
                    result <= {sum_d, result[W-1:DIGIT_W]};
                    carry  <= cout_d;
                    nz     <= nz | (sum_d != '0);
                    cnt    <= cnt + 1'b1;
                    if (last_digit) begin
                        cnt <= '0;
                        if (!op_q) begin
                            carry_out <= cout_d;
                            state     <= FIN;
                        end else if (!cout_d) begin
                            // a < b: result holds the ten's complement of the magnitude.
                            sign  <= 1'b1;
                            carry <= 1'b1;
                            state <= RECOMP;
                        end else if (grs_q != '0) begin
                            if (mag_zero) begin
                                sign  <= 1'b1;
                                state <= FIN;
                            end else begin
                                carry <= 1'b0;
                                state <= DEC;
                            end
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RECOMP, DEC: begin
                    result <= {sum_d, result[W-1:DIGIT_W]};
                    carry  <= cout_d;
                    cnt    <= cnt + 1'b1;
                    if (last_digit) begin
                        cnt   <= '0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - directed self-checking bench for bcd_addsub_serial
module tb_bcd_addsub_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [27:0] a = '0;
    logic [27:0] b = '0;
    logic [8:0]  grs = '0;
    logic        busy;
    logic        done;
    logic [27:0] result;
    logic        sign;
    logic        carry_out;
    logic        invalid;

    int total = 0;
    int bad   = 0;

    bcd_addsub_serial #(.NDIGITS(7), .GRS_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .grs       (grs),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sign      (sign),
        .carry_out (carry_out),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    // Launch one operation and count cycles from the accept edge until done.
    task automatic run_op(input bit sync, input logic o, input logic [27:0] av, input logic [27:0] bv,
                          input logic [8:0] gv, output int lat, output logic busy1);
        if (sync) begin
            @(posedge clk); #1;
        end
        start = 1'b1; op = o; a = av; b = bv; grs = gv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy1 = 1'b0;
        while (lat < 40 && !done) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) busy1 = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if ({result, sign, carry_out, invalid} !== 31'h0) begin bad++;
            $display("FAIL reset_outputs got=%h/%0b/%0b/%0b want=0", result, sign, carry_out, invalid); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat; logic b1;
        run_op(1, 1'b0, 28'h0000123, 28'h0000877, 9'h000, lat, b1);
        total++; if (lat !== 8) begin bad++; $display("FAIL add1_latency got=%0d want=8", lat); end
        total++; if (result !== 28'h0001000) begin bad++; $display("FAIL add1_result got=%h want=0001000", result); end
        total++; if ({carry_out, sign} !== 2'b00) begin bad++; $display("FAIL add1_flags got=%b want=00", {carry_out, sign}); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL add1_busy_during got=%0b want=1", b1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add1_busy_at_done got=%0b want=0", busy); end
        run_op(1, 1'b0, 28'h9999999, 28'h0000001, 9'h000, lat, b1);
        total++; if (result !== 28'h0000000) begin bad++; $display("FAIL add2_result got=%h want=0000000", result); end
        total++; if (carry_out !== 1'b1) begin bad++; $display("FAIL add2_carry got=%0b want=1", carry_out); end
    endtask

    task automatic test_sub_pos();
        int lat; logic b1;
        run_op(1, 1'b1, 28'h0000500, 28'h0000123, 9'h000, lat, b1);
        total++; if (lat !== 8) begin bad++; $display("FAIL sub_pos_latency got=%0d want=8", lat); end
        total++; if (result !== 28'h0000377) begin bad++; $display("FAIL sub_pos_result got=%h want=0000377", result); end
        total++; if ({sign, carry_out} !== 2'b00) begin bad++; $display("FAIL sub_pos_flags got=%b want=00", {sign, carry_out}); end
        run_op(1, 1'b1, 28'h0000500, 28'h0000123, 9'h001, lat, b1);
        total++; if (lat !== 15) begin bad++; $display("FAIL sub_dec_latency got=%0d want=15", lat); end
        total++; if (result !== 28'h0000376) begin bad++; $display("FAIL sub_dec_result got=%h want=0000376", result); end
        total++; if (sign !== 1'b0) begin bad++; $display("FAIL sub_dec_sign got=%0b want=0", sign); end
    endtask

    task automatic test_sub_neg();
        int lat; logic b1;
        run_op(1, 1'b1, 28'h0000123, 28'h0000500, 9'h000, lat, b1);
        total++; if (lat !== 15) begin bad++; $display("FAIL sub_neg_latency got=%0d want=15", lat); end
        total++; if (result !== 28'h0000377) begin bad++; $display("FAIL sub_neg_result got=%h want=0000377", result); end
        total++; if (sign !== 1'b1) begin bad++; $display("FAIL sub_neg_sign got=%0b want=1", sign); end
        run_op(1, 1'b1, 28'h0000500, 28'h0000500, 9'h004, lat, b1);
        total++; if (result !== 28'h0000000) begin bad++; $display("FAIL sub_zero_grs_result got=%h want=0000000", result); end
        total++; if (sign !== 1'b1) begin bad++; $display("FAIL sub_zero_grs_sign got=%0b want=1", sign); end
        total++; if (lat !== 8) begin bad++; $display("FAIL sub_zero_grs_latency got=%0d want=8", lat); end
        run_op(1, 1'b1, 28'h0000500, 28'h0000500, 9'h000, lat, b1);
        total++; if (result !== 28'h0000000) begin bad++; $display("FAIL sub_zero_result got=%h want=0000000", result); end
        total++; if (sign !== 1'b0) begin bad++; $display("FAIL sub_zero_sign got=%0b want=0", sign); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 28'h0000123; b = 28'h0000500; grs = 9'h000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        start = 1'b1; op = 1'b0; a = 28'h0000001; b = 28'h0000001;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 11;
        while (lat < 40 && !done) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 15) begin bad++; $display("FAIL ignore_latency got=%0d want=15", lat); end
        total++; if (result !== 28'h0000377) begin bad++; $display("FAIL ignore_result got=%h want=0000377", result); end
        total++; if (sign !== 1'b1) begin bad++; $display("FAIL ignore_sign got=%0b want=1", sign); end
        repeat (3) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%0b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 28'h0000123; b = 28'h0000500; grs = 9'h000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_busy_done got=%b want=00", {busy, done}); end
        total++; if ({result, sign, carry_out, invalid} !== 31'h0) begin bad++;
            $display("FAIL rstmid_outputs got=%h/%0b/%0b/%0b want=0", result, sign, carry_out, invalid); end
        seen_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%0b want=0", seen_done); end
    endtask

    task automatic test_invalid();
        int lat; logic b1;
        run_op(1, 1'b0, 28'h000000A, 28'h0000001, 9'h000, lat, b1);
        total++; if (lat !== 1) begin bad++; $display("FAIL invalid_latency got=%0d want=1", lat); end
        total++; if (invalid !== 1'b1) begin bad++; $display("FAIL invalid_flag got=%0b want=1", invalid); end
        total++; if (result !== 28'h0000000) begin bad++; $display("FAIL invalid_result got=%h want=0000000", result); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1;
        run_op(1, 1'b1, 28'h0000123, 28'h00B0500, 9'h000, lat, b1);
        total++; if (invalid !== 1'b1) begin bad++; $display("FAIL b2b_first_invalid got=%0b want=1", invalid); end
        run_op(0, 1'b0, 28'h0000123, 28'h0000877, 9'h000, lat, b1);
        total++; if (lat !== 8) begin bad++; $display("FAIL b2b_second_latency got=%0d want=8", lat); end
        total++; if (result !== 28'h0001000) begin bad++; $display("FAIL b2b_second_result got=%h want=0001000", result); end
        total++; if (invalid !== 1'b0) begin bad++; $display("FAIL b2b_invalid_cleared got=%0b want=0", invalid); end
        run_op(0, 1'b1, 28'h0000123, 28'h0000500, 9'h000, lat, b1);
        total++; if ({lat, result, sign} !== {32'd15, 28'h0000377, 1'b1}) begin bad++;
            $display("FAIL b2b_third got=%0d/%h/%0b want=15/0000377/1", lat, result, sign); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_pos();
        test_sub_neg();
        test_start_ignored();
        test_reset_mid();
        test_invalid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
